// File: rtl/ram16_arbiter.sv
// ram16_arbiter: two-port round-robin access controller for the 4x4 async RAM16.
// Each access is sequenced setup -> strobe/sample -> hold so address and data
// are stable around the asynchronous write strobe.
//
// Handshake (per port X = a/b): the requester raises x_req with x_wr/x_addr/
// x_wdata stable and keeps them until x_gnt. x_gnt is a one-cycle pulse that
// marks the fields as latched; x_req may drop any time afterwards. x_done is a
// one-cycle pulse when the access has finished (read data valid on x_rdata).
// An x_req still high in the x_done cycle is taken as a fresh request.
module ram16_arbiter #(
  parameter int WR_PULSE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic       b_req,
  input  logic       a_wr,
  input  logic       b_wr,
  input  logic [1:0] a_addr,
  input  logic [1:0] b_addr,
  input  logic [3:0] a_wdata,
  input  logic [3:0] b_wdata,
  output logic       a_gnt,
  output logic       b_gnt,
  output logic       a_done,
  output logic       b_done,
  output logic [3:0] a_rdata,
  output logic [3:0] b_rdata,
  output logic       busy,
  output logic       ram_en,
  output logic       ram_we,
  output logic [1:0] ram_a,
  output logic [3:0] ram_d,
  input  logic [3:0] ram_q,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_SAMPLE = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last;        // last granted port: 0 = A, 1 = B
  logic       op_port;     // port being serviced
  logic       op_wr;       // latched access direction
  logic [1:0] cnt;         // remaining strobe cycles minus one
  logic       grant;       // some request is pending
  logic       grant_port;  // port that wins arbitration this cycle

  // Arbitration: a lone request wins; on a tie the port not served last wins.
  always_comb begin
    grant      = a_req | b_req;
    grant_port = 1'b0;
    if (a_req && b_req) grant_port = ~last;
    else                grant_port = b_req;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    ram_en    = (state != S_IDLE);
    ram_we    = (state != S_STROBE);
    a_gnt     = (state == S_SETUP) && !op_port;
    b_gnt     = (state == S_SETUP) &&  op_port;
    state_dbg = state;
    case (state)
      S_IDLE:   if (grant) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = op_wr ? S_STROBE : S_SAMPLE;
      S_STROBE: if (cnt == 2'd0) state_nxt = S_HOLD;
      S_HOLD:   state_nxt = S_IDLE;
      S_SAMPLE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register; also flags an illegal strobe width in simulation.
  always_ff @(posedge clk) begin
    assert (WR_PULSE >= 1 && WR_PULSE <= 4)
      else $error("ram16_arbiter: WR_PULSE=%0d outside 1..4", WR_PULSE);
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operation registers, strobe counter, completion pulses and read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last    <= 1'b1;
      op_port <= 1'b0;
      op_wr   <= 1'b0;
      ram_a   <= 2'd0;
      ram_d   <= 4'd0;
      cnt     <= 2'd0;
      a_done  <= 1'b0;
      b_done  <= 1'b0;
      a_rdata <= 4'd0;
      b_rdata <= 4'd0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      // Address/data only ever change here, on the grant edge.
      if (state == S_IDLE && grant) begin
        op_port <= grant_port;
        last    <= grant_port;
        op_wr   <= grant_port ? b_wr    : a_wr;
        ram_a   <= grant_port ? b_addr  : a_addr;
        ram_d   <= grant_port ? b_wdata : a_wdata;
      end
      if (state == S_SETUP)                     cnt <= 2'(WR_PULSE - 1);
      else if (state == S_STROBE && cnt != 2'd0) cnt <= cnt - 2'd1;
      if (state == S_HOLD || state == S_SAMPLE) begin
        if (op_port) b_done <= 1'b1;
        else         a_done <= 1'b1;
      end
      if (state == S_SAMPLE) begin
        if (op_port) b_rdata <= ram_q;
        else         a_rdata <= ram_q;
      end
    end
  end

endmodule

// File: doc/ram16_arbiter.md
# ram16_arbiter

Two-port round-robin access controller for the 4-word × 4-bit asynchronous RAM16 macro. It accepts single-word read/write requests from two independent requesters (port A, port B) and serialises them onto the RAM's single shared address/data/control interface. It sequences every access as setup → strobe/sample → hold, so the asynchronous RAM always sees stable address and data around its write strobe. It sits between the requesters and the RAM16 instance; requesters never drive the RAM directly.

## Interface
Parameters:
- WR_PULSE, 1, number of cycles RAM_WE is held low (write strobe width); legal range 1–4.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  reset; one clock, reset is synchronous and active-low.
- A_REQ / B_REQ  in  1  access request; held high with fields stable until the matching GNT.
- A_WR / B_WR  in  1  1 = write, 0 = read.
- A_ADDR / B_ADDR  in  2  word address.
- A_WDATA / B_WDATA  in  4  write data.
- A_GNT / B_GNT  out  1  one-cycle pulse: request accepted, fields latched.
- A_DONE / B_DONE  out  1  one-cycle pulse: access complete.
- A_RDATA / B_RDATA  out  4  last read data for that port; valid from DONE, held until that port's next read DONE.
- BUSY  out  1  high in every non-IDLE state.
- RAM_EN  out  1  RAM chip select; high in SETUP/STROBE/HOLD/SAMPLE, low in IDLE.
- RAM_WE  out  1  RAM R/W: 0 = write, 1 = read; 0 only in STROBE.
- RAM_A  out  2  RAM address (latched).
- RAM_D  out  4  RAM write data (latched).
- RAM_Q  in  4  RAM read data.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, SAMPLE.
- IDLE: arbitrate each cycle. Only one REQ high → grant that port. Both high → grant the port ≠ LAST (round-robin pointer). None → stay in IDLE.
- On grant (edge leaving IDLE): latch WR/ADDR/WDATA into the op registers. RAM_A and RAM_D are driven from these registers. Set LAST to the granted port. Go to SETUP. The granted port's GNT is high for exactly the SETUP cycle.
- Write: SETUP (1 cycle, RAM_WE=1) → STROBE (WR_PULSE cycles, RAM_WE=0; internal 2-bit down-counter) → HOLD (1 cycle, RAM_WE=1, address/data unchanged) → IDLE.
- Read: SETUP (1 cycle) → SAMPLE (1 cycle) → IDLE. Capture RAM_Q into the granted port's RDATA on the edge leaving SAMPLE.
- DONE for the serviced port is registered and high during the first IDLE cycle after HOLD/SAMPLE. A new grant may be issued at the end of that same cycle.
- RAM_A and RAM_D are stable throughout SETUP..HOLD. They change only on a grant edge.
- Requester may drop REQ any time after GNT. REQ still high in the DONE cycle is treated as a new request.
- The non-serviced port's REQ is ignored while BUSY. It waits and keeps priority via LAST.

## Timing
- Reset values: state=IDLE, LAST=B (port A wins the first tie), all GNT/DONE=0, BUSY=0, RAM_EN=0, RAM_WE=1, RAM_A=0, RAM_D=0, A_RDATA=B_RDATA=0.
- Read latency: REQ sampled at edge 0 → GNT in cycle 1 → RDATA/DONE valid in cycle 3. Issue interval is 3 cycles.
- Write latency: DONE in cycle 3+WR_PULSE. Issue interval is 3+WR_PULSE cycles (4 with default).
- Reset asserted mid-operation: next edge forces the reset values. The in-flight access is aborted with no DONE. If aborted in STROBE, the addressed word's content is undefined; other words are untouched.
- Simultaneous REQ arriving in the DONE cycle of the other port: normal round-robin applies; the waiting port wins.
- WR_PULSE outside 1–4 is illegal: simulation-time error, no synthesis guarantee.

## Test plan
- Reset: hold RST_N=0 for 2 cycles with both REQ high → no GNT; RAM_EN=0, RAM_WE=1, outputs at reset values. Release → A_GNT pulses first.
- Single write/read: A writes 0xA to addr 2 → RAM_WE low exactly 1 cycle with RAM_A=2, RAM_D=0xA; A_DONE in cycle 4. A then reads addr 2 → A_RDATA=0xA with A_DONE in cycle 3.
- Contention: A and B hold REQ continuously (A writes addr0=0x5, B reads addr0) → grants alternate A, B, A, B. B's first read returns 0x5.
- Fill all four words from B (0x1, 0x2, 0x4, 0x8), then read back from A → data matches; RAM_A/RAM_D never change outside grant edges.
- WR_PULSE=3: write → RAM_WE low for exactly 3 cycles, DONE at cycle 6. Reset asserted in the 2nd STROBE cycle → no DONE, IDLE next cycle, LAST=B.
- Stale request: A keeps REQ high through its DONE → second GNT issued immediately. A drops REQ the cycle after GNT → exactly one access.
